// File: rtl/booth4_seq_mult16_pkg.sv
// Shared constants and FSM encoding for the sequential Radix-4 Booth multiplier.
//   DataW  : operand width (fixed at 16 by the partial-product decoder)
//   PpNum  : Booth digits per operand, one consumed per CALC cycle
//   CntW   : digit-counter width
//   MinNeg : most negative operand, whose negation is not representable
//   MinSq  : MinNeg * MinNeg, the only product the datapath cannot form itself
package booth4_seq_mult16_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned PpNum = DataW / 2;
    localparam int unsigned CntW  = 3;

    localparam logic [DataW-1:0]   MinNeg = 16'h8000;
    localparam logic [2*DataW-1:0] MinSq  = 32'h4000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/booth4_seq_mult16_pp_decoder.sv
// Radix-4 Booth partial-product decoder for one digit.
//   code_i  : 3-bit Booth window {b[2i+1], b[2i], b[2i-1]}
//   a_i     : multiplicand (two's complement, never 16'h8000 when used)
//   a_neg_i : precomputed -a_i
//   pp_o    : 17-bit partial product; bit 16 carries the INVERTED sign so the
//             consumer can sign-extend with ~pp_o[16]
module booth4_seq_mult16_pp_decoder
    import booth4_seq_mult16_pkg::*;
(
    input  logic [2:0]       code_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] a_neg_i,
    output logic [DataW:0]   pp_o
);

    // Signed 17-bit partial product in {-2A, -A, 0, +A, +2A}
    logic [DataW:0] pp_val;

    always_comb begin
        pp_val = '0;
        unique case (code_i)
            3'b001, 3'b010: pp_val = {a_i[DataW-1], a_i};
            3'b011:         pp_val = {a_i, 1'b0};
            3'b100:         pp_val = {a_neg_i, 1'b0};
            3'b101, 3'b110: pp_val = {a_neg_i[DataW-1], a_neg_i};
            default:        pp_val = '0;
        endcase
    end

    assign pp_o = {~pp_val[DataW], pp_val[DataW-1:0]};

endmodule

// File: rtl/booth4_seq_mult16.sv
// Iterative signed 16x16->32 multiplier: one shared Radix-4 Booth decoder,
// one digit per cycle, weight-shifted into a 32-bit accumulator.
//   sys_clk / sys_rst_n : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a_in / b_in         : multiplicand / multiplier, two's complement
//   out_valid/out_ready : product handshake (out_valid high only in DONE)
//   product             : exact signed a_in*b_in, held until accepted
//   busy                : an operation is in flight or awaiting pickup
module booth4_seq_mult16
    import booth4_seq_mult16_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataW-1:0]     a_in,
    input  logic [DataW-1:0]     b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DataW-1:0]   product,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*DataW-1:0]   acc_q, acc_d;
    logic [DataW-1:0]     a_q, a_d;
    logic [DataW-1:0]     a_neg_q, a_neg_d;
    logic [DataW:0]       b_sh_q, b_sh_d;
    logic                 both_min_q, both_min_d;
    logic [2*DataW-1:0]   product_q, product_d;

    logic [DataW-1:0]     a_sel, b_sel;
    logic [DataW:0]       pp_out;
    logic [2*DataW-1:0]   pp_ext;
    logic [2*DataW-1:0]   acc_sum;

    // -MinNeg does not fit in 16 bits, so keep MinNeg on the multiplier side
    assign a_sel = (a_in == MinNeg) ? b_in : a_in;
    assign b_sel = (a_in == MinNeg) ? a_in : b_in;

    booth4_seq_mult16_pp_decoder u_booth2_pp_decoder (
        .code_i  (b_sh_q[2:0]),
        .a_i     (a_q),
        .a_neg_i (a_neg_q),
        .pp_o    (pp_out)
    );

    assign pp_ext  = {{DataW{~pp_out[DataW]}}, pp_out[DataW-1:0]};
    assign acc_sum = acc_q + (pp_ext << {cnt_q, 1'b0});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        a_d        = a_q;
        a_neg_d    = a_neg_q;
        b_sh_d     = b_sh_q;
        both_min_d = both_min_q;
        product_d  = product_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d        = a_sel;
                    a_neg_d    = ~a_sel + 1'b1;
                    b_sh_d     = {b_sel, 1'b0};
                    both_min_d = (a_in == MinNeg) && (b_in == MinNeg);
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                acc_d  = acc_sum;
                b_sh_d = {b_sh_q[DataW], b_sh_q[DataW], b_sh_q[DataW:2]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntW'(PpNum - 1)) begin
                    // MinNeg*MinNeg is the one case the negation trick cannot cover
                    product_d = both_min_q ? MinSq : acc_sum;
                    cnt_d     = '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            a_q        <= '0;
            a_neg_q    <= '0;
            b_sh_q     <= '0;
            both_min_q <= 1'b0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            a_neg_q    <= a_neg_d;
            b_sh_q     <= b_sh_d;
            both_min_q <= both_min_d;
            product_q  <= product_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign product   = product_q;

endmodule

// File: tb/tb_booth4_seq_mult16.sv
// Scoreboard bench for booth4_seq_mult16: the driver pushes the expected
// product and accept edge when a handshake is seen; an independent monitor
// pops and compares on each new out_valid, and checks hold/drop behaviour.
module tb_booth4_seq_mult16;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] a_in      = '0;
    logic [15:0] b_in      = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    logic [31:0] exp_q[$];
    int unsigned lat_q[$];

    booth4_seq_mult16 dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact signed product, plain integer arithmetic
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 32'(sa * sb);
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [6];
        corners = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h8001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    // Called just after a rising edge; returns just after the accept edge
    task automatic send(input logic [15:0] a, input logic [15:0] b, output int unsigned acc_edge);
        int budget;
        budget   = 0;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(negedge sys_clk);
        while (!in_ready && budget < 40) begin
            @(negedge sys_clk);
            budget++;
        end
        if (!in_ready) begin
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
            $fatal(1, "operand never accepted");
        end
        acc_edge = cyc + 1;
        exp_q.push_back(ref_mul(a, b));
        lat_q.push_back(acc_edge);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge sys_clk);
            budget++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge sys_clk);
        #1;
    endtask

    // Monitor: compares each new product and checks hold / single-cycle valid
    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic [31:0] prev_prod;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_prod  = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_product", product, prev_prod);
                end
                if (prev_valid && prev_ready) check("valid_one_cycle", 32'(out_valid), 32'd0);
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", product, 32'hxxxx_xxxx);
                    end else begin
                        check("product", product, exp_q.pop_front());
                        check("latency", cyc - lat_q.pop_front(), 32'd8);
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_prod  = product;
            end
        end
    end

    initial begin
        int unsigned e;
        int unsigned last_e;
        int unsigned hs_edge;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", product, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Directed values, including the swap and MinNeg*MinNeg paths
        send(16'd3, 16'd5, e);           drain();
        send(16'hFFFF, 16'd1, e);        drain();
        send(16'h7FFF, 16'h7FFF, e);     drain();
        send(16'h7FFF, 16'h8000, e);     drain();
        send(16'h8000, 16'd3, e);        drain();
        send(16'h8000, 16'h8000, e);     drain();
        send(16'h8000, 16'd0, e);        drain();

        // Backpressure: product held, new operands refused until handshake
        out_ready = 1'b0;
        send(16'd1234, 16'hFFF0, e);
        begin
            int budget;
            budget = 0;
            while (!out_valid && budget < 20) begin
                @(negedge sys_clk);
                budget++;
            end
            check("bp_valid_seen", 32'(out_valid), 32'd1);
        end
        a_in     = 16'h0ABC;
        b_in     = 16'h0123;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge sys_clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge sys_clk);
        #1;
        out_ready = 1'b1;
        hs_edge   = cyc + 1;
        send(16'h0ABC, 16'h0123, e);
        check("bp_accept_edge", e, hs_edge + 1);
        drain();

        // Reset in the 4th CALC cycle discards the operation
        send(16'd9, 16'd9, e);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_product", product, 32'd0);
        send(16'd100, 16'hFFF9, e);
        drain();

        // Back-to-back random traffic at the minimum issue period
        last_e = 0;
        for (int i = 0; i < 2000; i++) begin
            send(pick_operand(), pick_operand(), e);
            if (i > 0) check("issue_period", e - last_e, 32'd10);
            last_e = e;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
